// File: rtl/sar_search_pkg.sv
// Shared types and constants for the successive-approximation search engine.
package sar_search_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TRIAL  = 2'd1,
    VERIFY = 2'd2,
    DONE   = 2'd3
  } sar_state_t;

  localparam int SAR_WIDTH = 4;

  // Value with only the most significant bit of a width-bit word set.
  function automatic logic [31:0] first_probe(input int width);
    return 32'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/sar_search_cmp_flag_check.sv
// Combinational sanity check: exactly one comparator flag must be high.
module cmp_flag_check (
  input  logic a_bigger,
  input  logic b_bigger,
  input  logic equals,
  output logic bad
);

  // XOR is high for one or three set flags; the AND term rejects three.
  assign bad = !(a_bigger ^ b_bigger ^ equals) || (a_bigger && b_bigger && equals);

endmodule

// File: rtl/sar_search.sv
// Successive-approximation search driving a magnitude comparator's probe operand.
// Optional macro SAR_EARLY_EXIT_EN ends the search on an equals flag during a trial.
module sar_search
  import sar_search_pkg::*;
#(
  parameter int WIDTH = SAR_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [WIDTH-1:0] probe,
  input  logic             cmp_a_bigger,
  input  logic             cmp_b_bigger,
  input  logic             cmp_equals,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             found,
  output logic             err
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  sar_state_t       state_reg, state_next;
  logic [WIDTH-1:0] probe_reg, probe_next;
  logic [WIDTH-1:0] result_reg, result_next;
  logic [IW-1:0]    idx_reg, idx_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;
  logic             found_reg, found_next;
  logic             err_reg, err_next;
  logic [WIDTH-1:0] cand;
  logic [IW-1:0]    idx_dec;
  logic             bad;

  cmp_flag_check u_flag_check (
    .a_bigger (cmp_a_bigger),
    .b_bigger (cmp_b_bigger),
    .equals   (cmp_equals),
    .bad      (bad)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      probe_reg  <= '0;
      result_reg <= '0;
      idx_reg    <= '0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      found_reg  <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      probe_reg  <= probe_next;
      result_reg <= result_next;
      idx_reg    <= idx_next;
      busy_reg   <= busy_next;
      done_reg   <= done_next;
      found_reg  <= found_next;
      err_reg    <= err_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    probe_next  = probe_reg;
    result_next = result_reg;
    idx_next    = idx_reg;
    busy_next   = busy_reg;
    done_next   = 1'b0;
    found_next  = found_reg;
    err_next    = err_reg;
    cand        = probe_reg;
    idx_dec     = idx_reg - 1'b1;

    case (state_reg)
      IDLE: begin
        probe_next = result_reg;
        if (start) begin
          state_next = TRIAL;
          probe_next = WIDTH'(first_probe(WIDTH));
          idx_next   = IW'(WIDTH - 1);
          busy_next  = 1'b1;
          found_next = 1'b0;
          err_next   = 1'b0;
        end
      end

      TRIAL: begin
        if (bad) begin
          err_next    = 1'b1;
          found_next  = 1'b0;
          result_next = probe_reg;
          busy_next   = 1'b0;
          done_next   = 1'b1;
          state_next  = DONE;
        end
`ifdef SAR_EARLY_EXIT_EN
        else if (cmp_equals) begin
          found_next  = 1'b1;
          result_next = probe_reg;
          busy_next   = 1'b0;
          done_next   = 1'b1;
          state_next  = DONE;
        end
`endif
        else begin
          // Probe above target means the trial bit overshoots and is dropped.
          if (cmp_a_bigger) cand[idx_reg] = 1'b0;
          if (idx_reg != '0) begin
            cand[idx_dec] = 1'b1;
            idx_next      = idx_dec;
            probe_next    = cand;
          end else begin
            probe_next  = cand;
            result_next = cand;
            state_next  = VERIFY;
          end
        end
      end

      VERIFY: begin
        if (bad) begin
          err_next    = 1'b1;
          found_next  = 1'b0;
          result_next = probe_reg;
        end else begin
          found_next = cmp_equals;
        end
        busy_next  = 1'b0;
        done_next  = 1'b1;
        state_next = DONE;
      end

      DONE: begin
        state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

  assign probe  = probe_reg;
  assign result = result_reg;
  assign busy   = busy_reg;
  assign done   = done_reg;
  assign found  = found_reg;
  assign err    = err_reg;

endmodule

// File: tb/tb_sar_search.sv
// Directed bench for sar_search against a behavioural 4-bit comparator.
module tb_sar_search;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] probe;
  logic       cmp_a_bigger, cmp_b_bigger, cmp_equals;
  logic       busy, done, found, err;
  logic [3:0] result;
  logic [3:0] target = 4'd0;
  logic       force_bad = 1'b0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign cmp_a_bigger = force_bad ? 1'b1 : (probe > target);
  assign cmp_b_bigger = force_bad ? 1'b1 : (probe < target);
  assign cmp_equals   = force_bad ? 1'b0 : (probe == target);

  sar_search #(.WIDTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .probe        (probe),
    .cmp_a_bigger (cmp_a_bigger),
    .cmp_b_bigger (cmp_b_bigger),
    .cmp_equals   (cmp_equals),
    .busy         (busy),
    .done         (done),
    .result       (result),
    .found        (found),
    .err          (err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts a search and waits (bounded) for done; lat counts edges after E0.
  task automatic run_search(input logic [3:0] t, output int lat,
                            output logic [3:0] res, output logic fnd, output logic er);
    target = t;
    start  = 1'b1;
    tick();
    start = 1'b0;
    lat   = 0;
    while (!done && lat < 20) begin
      tick();
      lat++;
    end
    res = result;
    fnd = found;
    er  = err;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({probe, result, busy, done, found, err} !== 12'h000) begin
      errors++;
      $display("FAIL reset_state: got probe=%0d result=%0d busy=%b done=%b found=%b err=%b, want all 0",
               probe, result, busy, done, found, err);
    end
    rst = 1'b0;
    tick();
    $display("reset: probe=%0d result=%0d busy=%b done=%b", probe, result, busy, done);
  endtask

  task automatic test_full_search();
    logic [3:0] exp_probe [5];
    exp_probe = '{4'd8, 4'd4, 4'd6, 4'd5, 4'd5};
    target = 4'd5;
    start  = 1'b1;
    tick();
    start = 1'b0;
`ifdef SAR_EARLY_EXIT_EN
    // Probe 5 matches on the fourth trial, so done follows E4.
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (probe !== exp_probe[k] || busy !== 1'b1) begin
        errors++;
        $display("FAIL full_probe%0d: got probe=%0d busy=%b, want probe=%0d busy=1", k, probe, busy, exp_probe[k]);
      end
      tick();
    end
`else
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (probe !== exp_probe[k] || busy !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL full_probe%0d: got probe=%0d busy=%b done=%b, want probe=%0d busy=1 done=0",
                 k, probe, busy, done, exp_probe[k]);
      end
      tick();
    end
`endif
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || result !== 4'd5 || found !== 1'b1 || err !== 1'b0) begin
      errors++;
      $display("FAIL full_done: got done=%b busy=%b result=%0d found=%b err=%b, want 1 0 5 1 0",
               done, busy, result, found, err);
    end
    tick();
    checks++;
    if (done !== 1'b0 || probe !== 4'd5 || result !== 4'd5) begin
      errors++;
      $display("FAIL full_idle: got done=%b probe=%0d result=%0d, want done=0 probe=5 result=5", done, probe, result);
    end
    $display("full search: target=5 result=%0d found=%b", result, found);
  endtask

  task automatic test_early_exit();
    int lat;
    logic [3:0] res;
    logic fnd, er;
    int exp_lat;
`ifdef SAR_EARLY_EXIT_EN
    exp_lat = 1;
`else
    exp_lat = 5;
`endif
    run_search(4'd8, lat, res, fnd, er);
    checks++;
    if (lat !== exp_lat || res !== 4'd8 || fnd !== 1'b1 || er !== 1'b0) begin
      errors++;
      $display("FAIL early_exit: got lat=%0d result=%0d found=%b err=%b, want lat=%0d result=8 found=1 err=0",
               lat, res, fnd, er, exp_lat);
    end
    $display("target=8: latency=%0d result=%0d found=%b", lat, res, fnd);
  endtask

  task automatic test_extremes();
    int lat;
    logic [3:0] res;
    logic fnd, er;
    int exp_lat15;
`ifdef SAR_EARLY_EXIT_EN
    exp_lat15 = 4;
`else
    exp_lat15 = 5;
`endif
    run_search(4'd0, lat, res, fnd, er);
    checks++;
    if (lat !== 5 || res !== 4'd0 || fnd !== 1'b1 || er !== 1'b0) begin
      errors++;
      $display("FAIL extreme_zero: got lat=%0d result=%0d found=%b err=%b, want lat=5 result=0 found=1 err=0",
               lat, res, fnd, er);
    end
    $display("target=0: latency=%0d result=%0d found=%b", lat, res, fnd);
    run_search(4'd15, lat, res, fnd, er);
    checks++;
    if (lat !== exp_lat15 || res !== 4'd15 || fnd !== 1'b1 || er !== 1'b0) begin
      errors++;
      $display("FAIL extreme_max: got lat=%0d result=%0d found=%b err=%b, want lat=%0d result=15 found=1 err=0",
               lat, res, fnd, er, exp_lat15);
    end
    $display("target=15: latency=%0d result=%0d found=%b", lat, res, fnd);
  endtask

  task automatic test_bad_flags();
    target = 4'd5;
    start  = 1'b1;
    tick();
    start = 1'b0;
    tick();
    checks++;
    if (probe !== 4'd4) begin
      errors++;
      $display("FAIL bad_second_probe: got probe=%0d, want 4", probe);
    end
    force_bad = 1'b1;
    tick();
    force_bad = 1'b0;
    checks++;
    if (done !== 1'b1 || err !== 1'b1 || found !== 1'b0 || result !== 4'd4 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bad_flags: got done=%b err=%b found=%b result=%0d busy=%b, want 1 1 0 4 0",
               done, err, found, result, busy);
    end
    $display("bad flags: done=%b err=%b result=%0d", done, err, result);
    tick();
  endtask

  task automatic test_target_change();
    int n_done = 0;
    logic fnd = 1'b1;
    logic er = 1'b1;
    logic [3:0] res = '0;
    target = 4'd3;
    start  = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    target = 4'd12;
    start  = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (done) begin
        n_done++;
        fnd = found;
        er  = err;
        res = result;
      end
      tick();
    end
    checks++;
    if (n_done !== 1 || fnd !== 1'b0 || er !== 1'b0 || res !== 4'd3) begin
      errors++;
      $display("FAIL target_change: got done_pulses=%0d found=%b err=%b result=%0d, want 1 0 0 3",
               n_done, fnd, er, res);
    end
    $display("target change: done_pulses=%0d found=%b err=%b result=%0d", n_done, fnd, er, res);
  endtask

  task automatic test_reset_mid();
    int n_done = 0;
    int lat;
    logic [3:0] res;
    logic fnd, er;
    target = 4'd9;
    start  = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({probe, result, busy, done, found, err} !== 12'h000) begin
      errors++;
      $display("FAIL reset_mid: got probe=%0d result=%0d busy=%b done=%b found=%b err=%b, want all 0",
               probe, result, busy, done, found, err);
    end
    tick();
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (done) n_done++;
      tick();
    end
    checks++;
    if (n_done !== 0) begin
      errors++;
      $display("FAIL reset_no_done: got done_pulses=%0d, want 0", n_done);
    end
    run_search(4'd9, lat, res, fnd, er);
    checks++;
    if (res !== 4'd9 || fnd !== 1'b1 || er !== 1'b0) begin
      errors++;
      $display("FAIL reset_rerun: got result=%0d found=%b err=%b, want 9 1 0", res, fnd, er);
    end
    $display("reset mid-search then target=9: result=%0d found=%b", res, fnd);
  endtask

  task automatic test_back_to_back();
    int lat = 0;
    target = 4'd2;
    start  = 1'b1;
    tick();
    while (!done && lat < 20) begin
      tick();
      lat++;
    end
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle: got busy=%b done=%b, want 0 0", busy, done);
    end
    tick();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || probe !== 4'd8) begin
      errors++;
      $display("FAIL b2b_restart: got busy=%b probe=%0d, want busy=1 probe=8", busy, probe);
    end
    $display("back to back: restart busy=%b probe=%0d", busy, probe);
    lat = 0;
    while (!done && lat < 20) begin
      tick();
      lat++;
    end
    checks++;
    if (result !== 4'd2 || found !== 1'b1) begin
      errors++;
      $display("FAIL b2b_result: got result=%0d found=%b, want 2 1", result, found);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_full_search();
    test_early_exit();
    test_extremes();
    test_bad_flags();
    test_target_change();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sar_search.md
# sar_search

Successive-approximation search engine that drives the probe (`a`) operand of the 4-bit magnitude comparator. It reads back the comparator's `a_bigger`, `b_bigger` and `equals` flags and recovers an unknown target value wired to the comparator's `b` operand. It runs one trial per clock cycle and reports the result with a done pulse. It is the initiator that drives the comparator from the other side of its interface. It checks that the three flags are one-hot and aborts the search if they are not.

## Interface

Parameters:
- `WIDTH`, default 4. Probe and result width; must match the comparator operand width.

Ports:
- `clk`, input, 1. Single clock; all state changes on the rising edge.
- `rst`, input, 1. Reset, asynchronous and active-high.
- `start`, input, 1. Request a search; sampled only in IDLE.
- `probe`, output, WIDTH. Trial value, registered; drives comparator `a3..a0`, MSB = `a3`.
- `cmp_a_bigger`, input, 1. Comparator flag: probe > target.
- `cmp_b_bigger`, input, 1. Comparator flag: probe < target.
- `cmp_equals`, input, 1. Comparator flag: probe == target.
- `busy`, output, 1. High from the cycle after `start` is accepted until DONE is entered.
- `done`, output, 1. One-cycle pulse: `result`, `found` and `err` are valid.
- `result`, output, WIDTH. Recovered target; held until the next accepted `start`.
- `found`, output, 1. High if the final verify or early exit saw `cmp_equals`.
- `err`, output, 1. High if the flags were not one-hot during a sampled cycle of this search.

## Operation

- States: IDLE, TRIAL, VERIFY, DONE. Reset places the block in IDLE with `probe`, `result`, `busy`, `done`, `found` and `err` all 0.
- **IDLE**
  - `probe` equals `result`.
  - `start`=1 at an edge → TRIAL with `probe = 1 << (WIDTH-1)`, bit index `i = WIDTH-1`, `busy`=1, and `found`/`err` cleared.
- **TRIAL**: the comparator is combinational, so the flags are sampled at the edge that ends the cycle in which the probe was presented. At each edge:
  - If `cmp_a_bigger`, clear bit `i`; otherwise keep it.
  - If `i` > 0, set bit `i-1` and decrement `i`.
  - If `i` == 0, move the candidate to `result`/`probe` and go to VERIFY.
- **VERIFY**: the probe holds the candidate for one cycle. At the edge, `found` = `cmp_equals` → DONE.
- **DONE**: `done`=1 and `busy`=0 for exactly one cycle → IDLE.
- **Flag check**: at every TRIAL/VERIFY edge, the number of high flags must be exactly one. Otherwise: `err`=1, `found`=0, `result` = current probe, → DONE.
- `start` while not in IDLE is ignored and not queued. `start` high in DONE is also ignored; it is accepted in the following IDLE cycle.
- If the target changes mid-search, VERIFY yields `found`=0 and no error.
- Asserting `rst` mid-search returns immediately to IDLE with all outputs 0. No done pulse is produced.

## Timing

- Call the edge that accepts `start` E0. The first probe is presented in the cycle after E0.
- Full search: the decisions occur at E1..E_WIDTH, VERIFY ends at E_(WIDTH+1), and `done` is high in the cycle after E_(WIDTH+1). For WIDTH=4 that is done after E5, a latency of WIDTH+2 cycles.
- `busy` is high in the cycles after E0 through E_(WIDTH+1).
- Back-to-back: the earliest next accepted `start` is at the edge ending the IDLE cycle that follows DONE.
- `probe` only changes on edges. It never glitches, and the comparator settles within the same cycle.

## Configuration

- Macro: `SAR_EARLY_EXIT_EN`.
- Defined: in TRIAL, `cmp_equals` at an edge ends the search.
  - Effects: `result` = current probe, `found`=1, → DONE, skipping the remaining trials and VERIFY.
  - Latency: done follows edge Ek, where k is the trial that matched.
- Undefined: `cmp_equals` in TRIAL is treated as "keep bit". The search always runs all WIDTH trials plus VERIFY.
- The flag check is active in both builds.

## Structure

- `sar_search_pkg` holds:
  - the state enum (IDLE, TRIAL, VERIFY, DONE);
  - the `SAR_WIDTH` default constant of 4;
  - a function `first_probe(width)` returning the MSB-only value.
- Sub-module: `cmp_flag_check`, a combinational check that the flags are one-hot with output `bad`. It is the only sub-module.

## Test plan

- **Full search, no early exit**: target=5, start pulse → probes 8, 4, 6, 5; then VERIFY 5; done after E5 with result=5, found=1, err=0.
- **Early exit build**: target=8 → probe 8 sees equals at E1; done in the next cycle with result=8, found=1, and busy high for 1 cycle.
- **Extremes**: target=0 → result=0 with all probes sampling a_bigger; target=15 → result=15. Both give found=1 with the full WIDTH+2 latency.
- **Bad flags**: force a_bigger=b_bigger=1 during the second trial → done next cycle with err=1, found=0.
- **Target changed**: target changes from 3 to 12 after E2 → done with found=0, err=0. A `start` during busy is ignored, so exactly one done pulse appears.
- **Reset mid-search**: assert rst after E2 → all outputs 0 immediately and no done pulse. A later start with target=9 gives result=9.
